tttg_move_sequencer: RTL and testbench

//  Front-end stage feeding the 2x2 game core. It debounces the raw play1/play2/cell push-buttons, latches
//  one selected cell, and enforces alternating turns. It then replays an accepted move to the core as the

---
 rtl/tttg_move_sequencer.sv | 161 ++++++++++++++++
 tb/tb_tttg_move_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tttg_move_sequencer.sv
// Move sequencer for the 2x2 game core: debounces buttons, latches a cell,
// enforces turns and replays accepted moves as play pulse then cell pulse.
module tttg_move_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit TURN_ENFORCE    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_play1,
  input  logic       raw_play2,
  input  logic [3:0] raw_cell,
  input  logic [3:0] occupied,
  input  logic       game_over,
  output logic       play1,
  output logic       play2,
  output logic [3:0] button,
  output logic       move_done,
  output logic       reject,
  output logic [1:0] turn
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CELL_SEL,
    ISSUE_PLAY,
    ISSUE_CELL
  } state_t;

  logic [5:0]    raw;
  logic [5:0]    s1_q, s2_q;
  logic [5:0]    lvl_q, lvl_d;
  logic [5:0]    ev_q, ev_d;
  logic [CW-1:0] cnt_q [6];
  logic [CW-1:0] cnt_d [6];

  assign raw = {raw_play2, raw_play1, raw_cell};

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CMAX) lvl_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    ev_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      ev_q  <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      ev_q  <= ev_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  state_t     state_q, state_d;
  logic [3:0] cell_q, cell_d;
  logic       who_q, who_d;
  logic [1:0] turn_q, turn_d;
  logic       rej_d;

  logic [3:0] cev;
  logic       p1e, p2e, pev;
  logic       cell_ok, cell_free, p1_ok, p2_ok;

  assign cev       = ev_q[3:0];
  assign p1e       = ev_q[4];
  assign p2e       = ev_q[5];
  assign pev       = p1e | p2e;
  assign cell_ok   = (cev != 4'd0) && ((cev & (cev - 4'd1)) == 4'd0)
                     && ((cev & occupied) == 4'd0);
  assign cell_free = (cell_q & occupied) == 4'd0;
  // turn 01 admits only player1, 10 only player2, 00 either
  assign p1_ok     = p1e & ~p2e & (turn_q != 2'b10);
  assign p2_ok     = p2e & ~p1e & (turn_q != 2'b01);

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    who_d   = who_q;
    turn_d  = turn_q;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!game_over && (cev != 4'd0 || pev)) begin
          if (cell_ok && !pev) begin
            cell_d  = cev;
            state_d = CELL_SEL;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      CELL_SEL: begin
        if (game_over) begin
          state_d = IDLE;
          cell_d  = 4'd0;
        end else if (cev != 4'd0 && pev) begin
          rej_d = 1'b1;
        end else if (cev != 4'd0) begin
          if (cell_ok) cell_d = cev;
          else rej_d = 1'b1;
        end else if (pev) begin
          if ((p1_ok || p2_ok) && cell_free) begin
            state_d = ISSUE_PLAY;
            who_d   = p2e;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ISSUE_PLAY: state_d = ISSUE_CELL;
      ISSUE_CELL: begin
        state_d = IDLE;
        cell_d  = 4'd0;
        if (TURN_ENFORCE) turn_d = who_q ? 2'b01 : 2'b10;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cell_q    <= '0;
      who_q     <= 1'b0;
      turn_q    <= 2'b00;
      play1     <= 1'b0;
      play2     <= 1'b0;
      button    <= '0;
      move_done <= 1'b0;
      reject    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      who_q     <= who_d;
      turn_q    <= turn_d;
      play1     <= (state_d == ISSUE_PLAY) && !who_d;
      play2     <= (state_d == ISSUE_PLAY) && who_d;
      button    <= (state_d == ISSUE_CELL) ? cell_q : 4'd0;
      move_done <= (state_d == ISSUE_CELL);
      reject    <= rej_d;
    end
  end

  assign turn = turn_q;

endmodule

// File: tb/tb_tttg_move_sequencer.sv
// Bench for tttg_move_sequencer: table of press steps plus hand sequences
// for debounce boundary, reset during issue, and free-turn mode.
module tb_tttg_move_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_play1, raw_play2, game_over;
  logic [3:0] raw_cell, occupied;

  logic       p1_a, p2_a, md_a, rej_a;
  logic [3:0] btn_a;
  logic [1:0] turn_a;
  logic       p1_b, p2_b, md_b, rej_b;
  logic [3:0] btn_b;
  logic [1:0] turn_b;

  always #5 clk = ~clk;

  tttg_move_sequencer #(.DEBOUNCE_CYCLES(4), .TURN_ENFORCE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .raw_play1(raw_play1), .raw_play2(raw_play2),
    .raw_cell(raw_cell), .occupied(occupied), .game_over(game_over),
    .play1(p1_a), .play2(p2_a), .button(btn_a),
    .move_done(md_a), .reject(rej_a), .turn(turn_a)
  );

  tttg_move_sequencer #(.DEBOUNCE_CYCLES(4), .TURN_ENFORCE(1'b0)) dut_free (
    .clk(clk), .reset(reset),
    .raw_play1(raw_play1), .raw_play2(raw_play2),
    .raw_cell(raw_cell), .occupied(occupied), .game_over(game_over),
    .play1(p1_b), .play2(p2_b), .button(btn_b),
    .move_done(md_b), .reject(rej_b), .turn(turn_b)
  );

  int         tp1_a = 0, tp2_a = 0, trej_a = 0, tbtn_a = 0, tmd_a = 0;
  int         tp1_b = 0, tbtn_b = 0;
  int         inv_err = 0;
  logic [3:0] lbtn_a = 4'd0, lbtn_b = 4'd0;
  logic       pp_a = 1'b0, pp_b = 1'b0;

  always @(negedge clk) begin
    if (p1_a) tp1_a++;
    if (p2_a) tp2_a++;
    if (rej_a) trej_a++;
    if (md_a) tmd_a++;
    if (btn_a != 4'd0) begin tbtn_a++; lbtn_a = btn_a; end
    if (p1_b) tp1_b++;
    if (btn_b != 4'd0) begin tbtn_b++; lbtn_b = btn_b; end
    if (p1_a && p2_a) inv_err++;
    if (p1_b && p2_b) inv_err++;
    if ((btn_a & (btn_a - 4'd1)) != 4'd0) inv_err++;
    if ((btn_b & (btn_b - 4'd1)) != 4'd0) inv_err++;
    if ((p1_a || p2_a) && btn_a != 4'd0) inv_err++;
    if ((p1_b || p2_b) && btn_b != 4'd0) inv_err++;
    if ((btn_a != 4'd0) != md_a) inv_err++;
    if (btn_a != 4'd0 && !pp_a) inv_err++;
    if (btn_b != 4'd0 && !pp_b) inv_err++;
    pp_a = p1_a | p2_a;
    pp_b = p1_b | p2_b;
  end

  typedef struct {
    logic [3:0] cells;
    logic       p1;
    logic       p2;
    logic [3:0] occ;
    logic       go;
    int         e_p1;
    int         e_p2;
    int         e_rej;
    logic [3:0] e_btn;
    logic [1:0] e_turn;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] c, input logic a,
                              input logic b, input logic [3:0] o,
                              input logic g, input int ep1, input int ep2,
                              input int er, input logic [3:0] eb,
                              input logic [1:0] et);
    vec_t v;
    v.cells = c; v.p1 = a; v.p2 = b; v.occ = o; v.go = g;
    v.e_p1 = ep1; v.e_p2 = ep2; v.e_rej = er; v.e_btn = eb; v.e_turn = et;
    return v;
  endfunction

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] c, input logic a, input logic b);
    @(negedge clk);
    raw_cell  = c;
    raw_play1 = a;
    raw_play2 = b;
    repeat (8) @(negedge clk);
    raw_cell  = 4'd0;
    raw_play1 = 1'b0;
    raw_play2 = 1'b0;
    repeat (10) @(negedge clk);
    #1;
  endtask

  vec_t tbl[19];

  initial begin
    int b_p1, b_p2, b_rej, b_btn, b_md, bb_p1, bb_btn;
    bit found;

    tbl[0]  = mk(4'b0100, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 2'b00);
    tbl[1]  = mk(4'b0000, 1, 0, 4'b0000, 0, 1, 0, 0, 4'b0100, 2'b10);
    tbl[2]  = mk(4'b0001, 0, 0, 4'b0100, 0, 0, 0, 0, 4'b0000, 2'b10);
    tbl[3]  = mk(4'b0000, 1, 0, 4'b0100, 0, 0, 0, 1, 4'b0000, 2'b10);
    tbl[4]  = mk(4'b0000, 0, 1, 4'b0100, 0, 0, 1, 0, 4'b0001, 2'b01);
    tbl[5]  = mk(4'b0011, 0, 0, 4'b0101, 0, 0, 0, 1, 4'b0000, 2'b01);
    tbl[6]  = mk(4'b0001, 0, 0, 4'b0101, 0, 0, 0, 1, 4'b0000, 2'b01);
    tbl[7]  = mk(4'b0010, 0, 0, 4'b0101, 0, 0, 0, 0, 4'b0000, 2'b01);
    tbl[8]  = mk(4'b0000, 0, 1, 4'b0101, 0, 0, 0, 1, 4'b0000, 2'b01);
    tbl[9]  = mk(4'b0000, 1, 0, 4'b0101, 0, 1, 0, 0, 4'b0010, 2'b10);
    tbl[10] = mk(4'b1000, 0, 0, 4'b0111, 0, 0, 0, 0, 4'b0000, 2'b10);
    tbl[11] = mk(4'b0000, 0, 1, 4'b1111, 0, 0, 0, 1, 4'b0000, 2'b10);
    tbl[12] = mk(4'b1000, 0, 0, 4'b0111, 1, 0, 0, 0, 4'b0000, 2'b10);
    tbl[13] = mk(4'b0000, 0, 1, 4'b0111, 1, 0, 0, 0, 4'b0000, 2'b10);
    tbl[14] = mk(4'b0000, 0, 1, 4'b0111, 0, 0, 0, 1, 4'b0000, 2'b10);
    tbl[15] = mk(4'b1000, 0, 1, 4'b0111, 0, 0, 0, 1, 4'b0000, 2'b10);
    tbl[16] = mk(4'b1000, 0, 0, 4'b0111, 0, 0, 0, 0, 4'b0000, 2'b10);
    tbl[17] = mk(4'b1000, 0, 1, 4'b0111, 0, 0, 0, 1, 4'b0000, 2'b10);
    tbl[18] = mk(4'b0000, 0, 1, 4'b0111, 0, 0, 1, 0, 4'b1000, 2'b01);

    reset = 1'b1;
    raw_play1 = 1'b0;
    raw_play2 = 1'b0;
    raw_cell = 4'd0;
    occupied = 4'd0;
    game_over = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_a", int'({p1_a, p2_a, btn_a, md_a, rej_a}), 0);
    check("reset_turn_a", int'(turn_a), 0);
    check("reset_outs_b", int'({p1_b, p2_b, btn_b, md_b, rej_b}), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      occupied  = tbl[i].occ;
      game_over = tbl[i].go;
      b_p1 = tp1_a; b_p2 = tp2_a; b_rej = trej_a;
      b_btn = tbl[i].e_btn == 4'd0 ? tbtn_a : tbtn_a; b_md = tmd_a;
      press(tbl[i].cells, tbl[i].p1, tbl[i].p2);
      check($sformatf("step%0d_play1", i), tp1_a - b_p1, tbl[i].e_p1);
      check($sformatf("step%0d_play2", i), tp2_a - b_p2, tbl[i].e_p2);
      check($sformatf("step%0d_reject", i), trej_a - b_rej, tbl[i].e_rej);
      check($sformatf("step%0d_button", i),
            (tbtn_a - b_btn) == 0 ? 0 : int'(lbtn_a), int'(tbl[i].e_btn));
      check($sformatf("step%0d_movedone", i), tmd_a - b_md,
            tbl[i].e_btn == 4'd0 ? 0 : 1);
      check($sformatf("step%0d_turn", i), int'(turn_a), int'(tbl[i].e_turn));
    end

    // debounce boundary: 3-cycle glitch is ignored, 4-cycle press is an event
    game_over = 1'b0;
    occupied  = 4'b1000;
    b_rej = trej_a;
    @(negedge clk);
    raw_cell = 4'b1000;
    repeat (3) @(negedge clk);
    raw_cell = 4'b0000;
    repeat (14) @(negedge clk);
    check("glitch3_no_event", trej_a - b_rej, 0);
    b_rej = trej_a;
    raw_cell = 4'b1000;
    repeat (4) @(negedge clk);
    raw_cell = 4'b0000;
    repeat (14) @(negedge clk);
    check("press4_event", trej_a - b_rej, 1);

    // reset during the play-pulse cycle aborts the move
    occupied = 4'd0;
    press(4'b0100, 1'b0, 1'b0);
    b_btn = tbtn_a; b_md = tmd_a; b_rej = trej_a;
    @(negedge clk);
    raw_play1 = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk);
      #1;
      if (p1_a) found = 1'b1;
    end
    check("issue_play_seen", int'(found), 1);
    reset = 1'b1;
    raw_play1 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_outs", int'({p1_a, p2_a, btn_a, md_a, rej_a}), 0);
    check("abort_turn", int'(turn_a), 0);
    repeat (12) @(negedge clk);
    #1;
    check("abort_no_button", tbtn_a - b_btn, 0);
    check("abort_no_movedone", tmd_a - b_md, 0);
    check("abort_no_reject", trej_a - b_rej, 0);

    // free-turn instance: player1 may move twice in a row
    bb_p1 = tp1_b; bb_btn = tbtn_b;
    press(4'b0001, 1'b0, 1'b0);
    press(4'b0000, 1'b1, 1'b0);
    check("free1_play1", tp1_b - bb_p1, 1);
    check("free1_button", int'(lbtn_b), 4'b0001);
    check("free1_turn", int'(turn_b), 0);
    occupied = 4'b0001;
    press(4'b0010, 1'b0, 1'b0);
    press(4'b0000, 1'b1, 1'b0);
    check("free2_play1", tp1_b - bb_p1, 2);
    check("free2_buttons", tbtn_b - bb_btn, 2);
    check("free2_button", int'(lbtn_b), 4'b0010);
    check("free2_turn", int'(turn_b), 0);

    check("invariants", inv_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
